// File: rtl/bcd_counter_pkg.sv
// Shared types, digit constants and the load clamp for the BCD counter.
package bcd_counter_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Preset nibbles outside 0..9 would break the carry chain, so pin them to 9.
  function automatic logic [BCD_W-1:0] clamp_nibble(input logic [BCD_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_counter_ctrl_digit.sv
// One BCD digit: combinational increment/decrement with carry/borrow ripple.
import bcd_counter_pkg::*;

module bcd_digit (
  input  logic [BCD_W-1:0] value,
  input  logic             dir,
  input  logic             cin,
  output logic [BCD_W-1:0] next_val,
  output logic             cout
);

  always_comb begin
    next_val = value;
    cout     = 1'b0;
    if (cin) begin
      if (!dir) begin
        if (value >= BCD_MAX) begin
          next_val = '0;
          cout     = 1'b1;
        end else begin
          next_val = value + BCD_W'(1);
        end
      end else begin
        if (value == '0) begin
          next_val = BCD_MAX;
          cout     = 1'b1;
        end else begin
          next_val = value - BCD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_ctrl.sv
// N-digit BCD up/down counter with pulse-toggled run/stop and direction,
// built-in tick divider, clear, clamped parallel load and wrap pulse.
//
//   state | meaning
//   ------+-----------------------------------------------
//   STOP  | divider frozen (phase kept), count holds
//   RUN   | divider advances, count steps on terminal count
import bcd_counter_pkg::*;

module bcd_counter_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_run,
  input  logic                    i_clear,
  input  logic                    i_mode,
  input  logic                    i_load,
  input  logic [BCD_W*DIGITS-1:0] i_load_val,
  output logic [BCD_W*DIGITS-1:0] o_bcd,
  output logic                    o_run,
  output logic                    o_mode,
  output logic                    o_wrap
);

  localparam int               W        = BCD_W * DIGITS;
  localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [W-1:0]     bcd_q;
  logic [W-1:0]     bcd_step;
  logic [W-1:0]     load_clamped;
  logic [DIGITS:0]  chain;
  logic             mode_q;
  logic             wrap_q;
  logic             tick;

  assign tick     = (state_q == RUN) && (div_q == DIV_LAST);
  assign chain[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .value    (bcd_q[g*BCD_W +: BCD_W]),
      .dir      (mode_q),
      .cin      (chain[g]),
      .next_val (bcd_step[g*BCD_W +: BCD_W]),
      .cout     (chain[g+1])
    );
    assign load_clamped[g*BCD_W +: BCD_W] = clamp_nibble(i_load_val[g*BCD_W +: BCD_W]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STOP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = STOP;
    end else if (i_run) begin
      state_d = (state_q == RUN) ? STOP : RUN;
    end
  end

  // The step always uses the registered direction, so a mode pulse on a
  // tick cycle only affects the following tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      bcd_q  <= '0;
      mode_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      mode_q <= mode_q ^ i_mode;
      if (i_clear) begin
        bcd_q <= '0;
        div_q <= '0;
      end else if (i_load) begin
        bcd_q <= load_clamped;
        div_q <= '0;
      end else if (tick) begin
        bcd_q  <= bcd_step;
        div_q  <= '0;
        wrap_q <= chain[DIGITS];
      end else if (state_q == RUN) begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  assign o_bcd  = bcd_q;
  assign o_run  = (state_q == RUN);
  assign o_mode = mode_q;
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Directed, table-driven bench for bcd_counter_ctrl with DIGITS=4, TICK_DIV=4.
module tb_bcd_counter_ctrl;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int W        = 4 * DIGITS;

  typedef struct {
    logic         run;
    logic         clr;
    logic         mode;
    logic         load;
    logic [W-1:0] lval;
    logic [W-1:0] bcd;
    logic         r;
    logic         m;
    logic         w;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_run = 1'b0;
  logic         i_clear = 1'b0;
  logic         i_mode = 1'b0;
  logic         i_load = 1'b0;
  logic [W-1:0] i_load_val = '0;
  logic [W-1:0] o_bcd;
  logic         o_run;
  logic         o_mode;
  logic         o_wrap;

  int   checks = 0;
  int   fails  = 0;
  int   row    = 0;
  vec_t vecs[$];

  bcd_counter_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_run      (i_run),
    .i_clear    (i_clear),
    .i_mode     (i_mode),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .o_bcd      (o_bcd),
    .o_run      (o_run),
    .o_mode     (o_mode),
    .o_wrap     (o_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int           v;
    r = '0;
    v = n;
    for (int d = 0; d < DIGITS; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string nm, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic run, input logic clr, input logic mode, input logic load,
                     input logic [W-1:0] lval, input logic [W-1:0] bcd,
                     input logic r, input logic m, input logic w);
    vec_t v;
    v.run = run; v.clr = clr; v.mode = mode; v.load = load; v.lval = lval;
    v.bcd = bcd; v.r = r; v.m = m; v.w = w;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input int n, input logic [W-1:0] bcd, input logic r, input logic m);
    for (int k = 0; k < n; k++) add(0, 0, 0, 0, '0, bcd, r, m, 0);
  endtask

  // Called at posedge+1; inputs are sampled at the next edge, outputs checked 1 time unit later.
  task automatic apply(input vec_t v, input int idx);
    i_run = v.run; i_clear = v.clr; i_mode = v.mode; i_load = v.load; i_load_val = v.lval;
    @(posedge clk);
    #1;
    i_run = 0; i_clear = 0; i_mode = 0; i_load = 0; i_load_val = '0;
    check("bcd",  idx, o_bcd,            v.bcd);
    check("run",  idx, W'(o_run),        W'(v.r));
    check("mode", idx, W'(o_mode),       W'(v.m));
    check("wrap", idx, W'(o_wrap),       W'(v.w));
  endtask

  initial begin
    vec_t v;

    // up count from reset: first step four cycles after run, then to 0012
    add(1, 0, 0, 0, '0, 16'h0000, 1, 0, 0);
    add_idle(3, 16'h0000, 1, 0);
    add_idle(1, 16'h0001, 1, 0);
    for (int t = 2; t <= 12; t++) begin
      add_idle(3, to_bcd(t - 1), 1, 0);
      add_idle(1, to_bcd(t), 1, 0);
    end
    // pause two cycles into the phase, resume one cycle from the next tick
    add_idle(2, 16'h0012, 1, 0);
    add(1, 0, 0, 0, '0, 16'h0012, 0, 0, 0);
    add_idle(5, 16'h0012, 0, 0);
    add(1, 0, 0, 0, '0, 16'h0012, 1, 0, 0);
    add_idle(1, 16'h0013, 1, 0);
    // up wrap
    add(0, 0, 0, 1, 16'h9998, 16'h9998, 1, 0, 0);
    add_idle(3, 16'h9998, 1, 0);
    add_idle(1, 16'h9999, 1, 0);
    add_idle(3, 16'h9999, 1, 0);
    add(0, 0, 0, 0, '0, 16'h0000, 1, 0, 1);
    add_idle(1, 16'h0000, 1, 0);
    // down wrap
    add(0, 1, 0, 0, '0, 16'h0000, 0, 0, 0);
    add(0, 0, 1, 0, '0, 16'h0000, 0, 1, 0);
    add(1, 0, 0, 0, '0, 16'h0000, 1, 1, 0);
    add_idle(3, 16'h0000, 1, 1);
    add(0, 0, 0, 0, '0, 16'h9999, 1, 1, 1);
    add_idle(3, 16'h9999, 1, 1);
    add_idle(1, 16'h9998, 1, 1);
    // mode toggle on a tick cycle: step still goes down
    add_idle(3, 16'h9998, 1, 1);
    add(0, 0, 1, 0, '0, 16'h9997, 1, 0, 0);
    add_idle(3, 16'h9997, 1, 0);
    add_idle(1, 16'h9998, 1, 0);
    // load clamp, then load on a tick cycle
    add(0, 0, 0, 1, 16'h9A3F, 16'h9939, 1, 0, 0);
    add_idle(3, 16'h9939, 1, 0);
    add(0, 0, 0, 1, 16'h0500, 16'h0500, 1, 0, 0);
    add_idle(3, 16'h0500, 1, 0);
    add_idle(1, 16'h0501, 1, 0);
    // clear beats run; clear with mode still toggles; divider restarts fresh
    add(0, 0, 0, 1, 16'h0123, 16'h0123, 1, 0, 0);
    add_idle(1, 16'h0123, 1, 0);
    add(1, 1, 0, 0, '0, 16'h0000, 0, 0, 0);
    add(0, 1, 1, 0, '0, 16'h0000, 0, 1, 0);
    add(0, 0, 1, 0, '0, 16'h0000, 0, 0, 0);
    add(1, 0, 0, 0, '0, 16'h0000, 1, 0, 0);
    add_idle(3, 16'h0000, 1, 0);
    add_idle(1, 16'h0001, 1, 0);
    // run pulse on a tick cycle: step happens, then STOP
    add_idle(3, 16'h0001, 1, 0);
    add(1, 0, 0, 0, '0, 16'h0002, 0, 0, 0);
    add_idle(4, 16'h0002, 0, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_bcd",  0, o_bcd,          '0);
    check("rst_run",  0, W'(o_run),      '0);
    check("rst_mode", 0, W'(o_mode),     '0);
    check("rst_wrap", 0, W'(o_wrap),     '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      apply(vecs[i], row);
      row++;
    end

    // async reset mid-run at 0057 with mode set
    v = '{run:0, clr:0, mode:1, load:1, lval:16'h0057, bcd:16'h0057, r:0, m:1, w:0};
    apply(v, row++);
    v = '{run:1, clr:0, mode:0, load:0, lval:'0, bcd:16'h0057, r:1, m:1, w:0};
    apply(v, row++);
    v = '{run:0, clr:0, mode:0, load:0, lval:'0, bcd:16'h0057, r:1, m:1, w:0};
    apply(v, row++);
    apply(v, row++);
    #2;
    rst = 1'b1;
    #1;
    check("arst_bcd",  row, o_bcd,      '0);
    check("arst_run",  row, W'(o_run),  '0);
    check("arst_mode", row, W'(o_mode), '0);
    check("arst_wrap", row, W'(o_wrap), '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_bcd", row, o_bcd,     '0);
    check("post_rst_run", row, W'(o_run), '0);
    v = '{run:1, clr:0, mode:0, load:0, lval:'0, bcd:16'h0000, r:1, m:0, w:0};
    apply(v, row++);
    v = '{run:0, clr:0, mode:0, load:0, lval:'0, bcd:16'h0000, r:1, m:0, w:0};
    for (int k = 0; k < 3; k++) apply(v, row++);
    v = '{run:0, clr:0, mode:0, load:0, lval:'0, bcd:16'h0001, r:1, m:0, w:0};
    apply(v, row++);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
